// File: rtl/xnor_bit_streamer_pkg.sv
// Shared constants for the XNOR bit streamer: FSM encoding, default sizes, counter width.
package xnor_bit_streamer_pkg;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int DEF_WORD_W = 16;
    localparam int DEF_N_BITS = 784;
    localparam int CNT_W      = 11;
endpackage

// File: rtl/xnor_bit_streamer_if.sv
// Word-fetch handshake between a word source (master) and the bit streamer (slave).
interface xnor_bit_streamer_if
    import xnor_bit_streamer_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
);
    logic              word_req;
    logic              word_vld;
    logic [WORD_W-1:0] x_word;
    logic [WORD_W-1:0] w_word;

    modport master (input word_req, output word_vld, output x_word, output w_word);
    modport slave  (output word_req, input word_vld, input x_word, input w_word);
endinterface

// File: rtl/xnor_bit_streamer_word_buf.sv
// One-entry x/w word buffer with valid flag, used to prefetch the next word while shifting.
module xnor_word_buf
    import xnor_bit_streamer_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              take,
    input  logic [WORD_W-1:0] x_in,
    input  logic [WORD_W-1:0] w_in,
    output logic [WORD_W-1:0] x_out,
    output logic [WORD_W-1:0] w_out,
    output logic              vld
);
    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= 1'b0;
            x_out <= '0;
            w_out <= '0;
        end else if (load) begin
            vld   <= 1'b1;
            x_out <= x_in;
            w_out <= w_in;
        end else if (take) begin
            vld   <= 1'b0;
        end
    end
endmodule

// File: rtl/xnor_bit_streamer.sv
// Streams XNOR(x,w) bits of one neuron to a downstream ones counter, one bit per cycle.
// Optional feature macro XNOR_PREFETCH_EN: prefetch buffer for bubble-free word changes.
module xnor_bit_streamer
    import xnor_bit_streamer_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int N_BITS = DEF_N_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic a,
    output logic ld,
    output logic cnt_clr,
    xnor_bit_streamer_if.slave wb
);
    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N_BITS - 1);
    localparam logic [BW-1:0]    LAST_POS = BW'(WORD_W - 1);

    logic [2:0]        state, state_nxt;
    logic [WORD_W-1:0] xs, ws, xs_nxt, ws_nxt;
    logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
    logic [CNT_W-1:0]  tot_cnt, tot_cnt_nxt;
    logic              xfer, word_last, bit_last;

    assign xfer      = wb.word_req & wb.word_vld;
    assign word_last = (bit_cnt == LAST_POS);
    assign bit_last  = (tot_cnt == LAST_BIT);

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign cnt_clr = (state == S_CLR);
    assign ld      = (state == S_SHIFT);
    assign a       = ld & ~(xs[0] ^ ws[0]);

`ifdef XNOR_PREFETCH_EN
    logic              buf_load, buf_take, buf_vld, more_words;
    logic [WORD_W-1:0] buf_x, buf_w;
    logic [CNT_W:0]    word_end;

    // First bit index past the word currently in the shift registers.
    assign word_end   = {1'b0, tot_cnt} - {{(CNT_W + 1 - BW){1'b0}}, bit_cnt}
                        + (CNT_W + 1)'(WORD_W);
    assign more_words = (word_end < (CNT_W + 1)'(N_BITS));
    assign wb.word_req = (state == S_FETCH)
                       | ((state == S_SHIFT) & ~buf_vld & more_words);

    xnor_word_buf #(.WORD_W(WORD_W)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .take  (buf_take),
        .x_in  (wb.x_word),
        .w_in  (wb.w_word),
        .x_out (buf_x),
        .w_out (buf_w),
        .vld   (buf_vld)
    );
`else
    assign wb.word_req = (state == S_FETCH);
`endif

    always_comb begin
        state_nxt   = state;
        xs_nxt      = xs;
        ws_nxt      = ws;
        bit_cnt_nxt = bit_cnt;
        tot_cnt_nxt = tot_cnt;
`ifdef XNOR_PREFETCH_EN
        buf_load    = 1'b0;
        buf_take    = 1'b0;
`endif
        case (state)
            S_IDLE: if (start) state_nxt = S_CLR;
            S_CLR: begin
                state_nxt   = S_FETCH;
                bit_cnt_nxt = '0;
                tot_cnt_nxt = '0;
            end
            S_FETCH: if (xfer) begin
                xs_nxt      = wb.x_word;
                ws_nxt      = wb.w_word;
                bit_cnt_nxt = '0;
                state_nxt   = S_SHIFT;
            end
            S_SHIFT: begin
                xs_nxt      = xs >> 1;
                ws_nxt      = ws >> 1;
                bit_cnt_nxt = bit_cnt + 1'b1;
                tot_cnt_nxt = tot_cnt + 1'b1;
                // The neuron end wins over the word end; leftover upper bits are dropped.
                if (bit_last) begin
                    state_nxt = S_DONE;
                end else if (word_last) begin
                    bit_cnt_nxt = '0;
`ifdef XNOR_PREFETCH_EN
                    if (buf_vld) begin
                        xs_nxt   = buf_x;
                        ws_nxt   = buf_w;
                        buf_take = 1'b1;
                    end else if (xfer) begin
                        xs_nxt = wb.x_word;
                        ws_nxt = wb.w_word;
                    end else begin
                        state_nxt = S_FETCH;
                    end
`else
                    state_nxt = S_FETCH;
`endif
                end
`ifdef XNOR_PREFETCH_EN
                else if (xfer) begin
                    buf_load = 1'b1;
                end
`endif
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            xs      <= '0;
            ws      <= '0;
            bit_cnt <= '0;
            tot_cnt <= '0;
        end else begin
            state   <= state_nxt;
            xs      <= xs_nxt;
            ws      <= ws_nxt;
            bit_cnt <= bit_cnt_nxt;
            tot_cnt <= tot_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_xnor_bit_streamer.sv
// Directed bench: three streamer instances (32, 20 and 784 bits) with a modelled ones counter.
module tb_xnor_bit_streamer;
    import xnor_bit_streamer_pkg::*;

    logic       clk;
    logic       rst;
    logic       mon_clr;
    logic [2:0] start_v, busy_v, done_v, a_v, ld_v, clr_v;

    int total = 0;
    int bad   = 0;

    int          ldn   [3];
    int          cnt   [3];
    int          dones [3];
    int          gaps  [3];
    int          aviol [3];
    int          clrs  [3];
    logic [31:0] seq   [3];

    xnor_bit_streamer_if #(.WORD_W(16)) if0 ();
    xnor_bit_streamer_if #(.WORD_W(16)) if1 ();
    xnor_bit_streamer_if #(.WORD_W(16)) if2 ();

    xnor_bit_streamer #(.WORD_W(16), .N_BITS(32)) u32 (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .a(a_v[0]), .ld(ld_v[0]), .cnt_clr(clr_v[0]), .wb(if0)
    );
    xnor_bit_streamer #(.WORD_W(16), .N_BITS(20)) u20 (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .a(a_v[1]), .ld(ld_v[1]), .cnt_clr(clr_v[1]), .wb(if1)
    );
    xnor_bit_streamer #(.WORD_W(16), .N_BITS(784)) u784 (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .a(a_v[2]), .ld(ld_v[2]), .cnt_clr(clr_v[2]), .wb(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ones counter plus activity statistics, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mon_clr) begin
                ldn[i] <= 0; cnt[i] <= 0; dones[i] <= 0;
                gaps[i] <= 0; aviol[i] <= 0; clrs[i] <= 0; seq[i] <= '0;
            end else begin
                if (ld_v[i]) ldn[i] <= ldn[i] + 1;
                if (ld_v[i] && ldn[i] < 32) seq[i][ldn[i][4:0]] <= a_v[i];
                if (clr_v[i]) cnt[i] <= 0;
                else if (ld_v[i] && a_v[i]) cnt[i] <= cnt[i] + 1;
                if (done_v[i]) dones[i] <= dones[i] + 1;
                if (clr_v[i]) clrs[i] <= clrs[i] + 1;
                if (busy_v[i] && !ld_v[i] && !clr_v[i] && !done_v[i]) gaps[i] <= gaps[i] + 1;
                if (!ld_v[i] && a_v[i]) aviol[i] <= aviol[i] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_until_idle(input int i, input int budget);
        for (int c = 0; c < budget && busy_v[i]; c++) tick();
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    logic xf;
    int   k;

    initial begin
        rst = 1'b1; mon_clr = 1'b1; start_v = '0;
        if0.word_vld = 1'b0; if0.x_word = '0; if0.w_word = '0;
        if1.word_vld = 1'b0; if1.x_word = '0; if1.w_word = '0;
        if2.word_vld = 1'b0; if2.x_word = '0; if2.w_word = '0;
        tick(); tick();
        rst = 1'b0; mon_clr = 1'b0;

        check("rst_busy", {29'd0, busy_v}, 32'd0);
        check("rst_done", {29'd0, done_v}, 32'd0);
        check("rst_ld",   {29'd0, ld_v},   32'd0);
        check("rst_a",    {29'd0, a_v},    32'd0);
        check("rst_clr",  {29'd0, clr_v},  32'd0);
        check("rst_req",  {29'd0, if2.word_req, if1.word_req, if0.word_req}, 32'd0);

        // 32 bits of all-ones words.
        if0.x_word = 16'hFFFF; if0.w_word = 16'hFFFF; if0.word_vld = 1'b1;
        start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
        check("t1_clr_pulse", {31'd0, clr_v[0]}, 32'd1);
        check("t1_busy",      {31'd0, busy_v[0]}, 32'd1);
        tick();
        check("t1_clr_once",  {31'd0, clr_v[0]}, 32'd0);
        check("t1_fetch_req", {31'd0, if0.word_req}, 32'd1);
        run_until_idle(0, 200);
        check("t1_idle",  {31'd0, busy_v[0]}, 32'd0);
        check("t1_ldn",   ldn[0],   32'd32);
        check("t1_cnt",   cnt[0],   32'd32);
        check("t1_done",  dones[0], 32'd1);
        check("t1_seq",   seq[0],   32'hFFFF_FFFF);
        check("t1_aviol", aviol[0], 32'd0);
`ifdef XNOR_PREFETCH_EN
        check("t1_gaps",  gaps[0],  32'd1);
`else
        check("t1_gaps",  gaps[0],  32'd2);
`endif

        // Partial final word: only its 4 LSBs are streamed.
        clear_mon();
        if1.x_word = 16'h00FF; if1.w_word = 16'h0000; if1.word_vld = 1'b1;
        start_v[1] = 1'b1; tick(); start_v[1] = 1'b0;
        k = 0;
        for (int c = 0; c < 100 && busy_v[1]; c++) begin
            xf = if1.word_req & if1.word_vld;
            tick();
            if (xf) begin
                k++;
                if1.x_word = 16'h000F; if1.w_word = 16'h000F;
            end
        end
        check("t2_idle",  {31'd0, busy_v[1]}, 32'd0);
        check("t2_words", k,        32'd2);
        check("t2_ldn",   ldn[1],   32'd20);
        check("t2_seq",   seq[1],   32'h000F_FF00);
        check("t2_cnt",   cnt[1],   32'd12);
        check("t2_done",  dones[1], 32'd1);

        // Full 784-bit neuron, all XNOR results zero.
        clear_mon();
        if2.x_word = 16'hAAAA; if2.w_word = 16'h5555; if2.word_vld = 1'b1;
        start_v[2] = 1'b1; tick(); start_v[2] = 1'b0;
        run_until_idle(2, 2000);
        check("t3_idle",  {31'd0, busy_v[2]}, 32'd0);
        check("t3_ldn",   ldn[2],   32'd784);
        check("t3_cnt",   cnt[2],   32'd0);
        check("t3_done",  dones[2], 32'd1);
        check("t3_aviol", aviol[2], 32'd0);
`ifdef XNOR_PREFETCH_EN
        check("t3_gaps",  gaps[2],  32'd1);
`else
        check("t3_gaps",  gaps[2],  32'd49);
`endif

        // Reset mid-stream, together with a start request, then restart.
        clear_mon();
        if2.x_word = 16'h00FF; if2.w_word = 16'h00FF;
        start_v[2] = 1'b1; tick(); start_v[2] = 1'b0;
        for (int c = 0; c < 500 && ldn[2] < 100; c++) tick();
        check("t4_reached_100", {31'd0, ldn[2] >= 100}, 32'd1);
        rst = 1'b1; start_v[2] = 1'b1;
        tick();
        rst = 1'b0; start_v[2] = 1'b0;
        check("t4_busy", {31'd0, busy_v[2]}, 32'd0);
        check("t4_outs", {27'd0, ld_v[2], a_v[2], done_v[2], clr_v[2], if2.word_req}, 32'd0);
        tick();
        check("t4_stay_idle", {31'd0, busy_v[2]}, 32'd0);
        clear_mon();
        start_v[2] = 1'b1; tick(); start_v[2] = 1'b0;
        check("t4_restart_clr", {31'd0, clr_v[2]}, 32'd1);
        run_until_idle(2, 2000);
        check("t4_ldn",  ldn[2],   32'd784);
        check("t4_cnt",  cnt[2],   32'd784);
        check("t4_done", dones[2], 32'd1);

        // Start while busy is ignored; a stalled fetch produces no ld.
        clear_mon();
        if0.word_vld = 1'b0; if0.x_word = 16'h00F0; if0.w_word = 16'h0F00;
        start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
        tick();
        start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
        repeat (3) tick();
        check("t5_stall_ld",  ldn[0], 32'd0);
        check("t5_stall_req", {31'd0, if0.word_req}, 32'd1);
        if0.word_vld = 1'b1;
        run_until_idle(0, 200);
        repeat (3) tick();
        check("t5_idle", {31'd0, busy_v[0]}, 32'd0);
        check("t5_ldn",  ldn[0],   32'd32);
        check("t5_cnt",  cnt[0],   32'd16);
        check("t5_done", dones[0], 32'd1);
        check("t5_clrs", clrs[0],  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
